pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the team's 32-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands, with wrap-around or signed-saturating arithmetic.
- The carry chain is split into STAGES registered slices to meet timing at wide WIDTH.
- Valid/ready streaming interface on both sides; sits between operand producers and consumers in datapath pipelines.

---
 rtl/adder_pkg.sv | 78 +++++++
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/adder_slice.sv | 78 +++++++
 rtl/pipelined_adder.sv | 99 +++++++++
 tb/tb_pipelined_adder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: operation encoding,
// saturation constants and a width-generic reference model of one beat.
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SADD = 2'b10,
        OP_SSUB = 2'b11
    } op_e;

    // Widest operand the reference model can represent.
    localparam int MAX_W = 128;

    typedef logic [MAX_W-1:0] wide_t;

    typedef struct packed {
        wide_t y;
        logic  carry;
        logic  ovf;
    } result_t;

    function automatic logic is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SSUB);
    endfunction

    function automatic logic is_sat(input op_e op);
        return (op == OP_SADD) || (op == OP_SSUB);
    endfunction

    // Low 'width' bits set.
    function automatic wide_t width_mask(input int width);
        if (width >= MAX_W) begin
            return '1;
        end
        return (wide_t'(1) << width) - wide_t'(1);
    endfunction

    // Signed minimum when sign is set, signed maximum otherwise.
    function automatic wide_t sat_value(input logic sign, input int width);
        wide_t min_v;
        min_v = wide_t'(1) << (width - 1);
        return sign ? min_v : (min_v - wide_t'(1));
    endfunction

    // One complete add/subtract on 'width'-bit operands, no pipelining.
    function automatic result_t ref_add(input wide_t a, input wide_t b,
                                        input op_e op, input int width);
        result_t          r;
        wide_t            m;
        wide_t            msb_m;
        wide_t            am_v;
        wide_t            bb;
        wide_t            raw;
        logic [MAX_W:0]   s;
        logic             c;
        logic             a_msb;
        logic             b_msb;
        logic             r_msb;
        logic             ovf;
        m     = width_mask(width);
        msb_m = wide_t'(1) << (width - 1);
        am_v  = a & m;
        bb    = (is_sub(op) ? ~b : b) & m;
        s     = {1'b0, am_v} + {1'b0, bb} + (MAX_W+1)'(is_sub(op));
        raw   = s[MAX_W-1:0] & m;
        c     = |(s & ((MAX_W+1)'(1) << width));
        a_msb = |(am_v & msb_m);
        b_msb = |(bb & msb_m);
        r_msb = |(raw & msb_m);
        ovf   = (a_msb == b_msb) && (r_msb != a_msb);
        r.y     = (is_sat(op) && ovf) ? sat_value(a_msb, width) : raw;
        r.carry = is_sub(op) ? ~c : c;
        r.ovf   = ovf;
        return r;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bus of the pipelined adder. The producer/consumer
// side uses the master modport, the adder itself uses the slave modport.
interface pipelined_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_e              in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_carry, out_ovf
    );
endinterface

// File: rtl/adder_slice.sv
// One pipeline stage: adds its WIDTH/STAGES-bit slice of the conditioned
// operands with the carry from the previous stage, and forwards operands,
// partial sum, carry and op downstream behind a valid/ready register.
module adder_slice
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    input  op_e              up_op,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_a,
    output logic [WIDTH-1:0] dn_b,
    output logic [WIDTH-1:0] dn_sum,
    output logic             dn_carry,
    output op_e              dn_op
);
    localparam int S  = WIDTH / STAGES;
    localparam int LO = IDX * S;

    logic             valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    op_e              op_reg;

    logic [S:0]       slice_sum;
    logic [WIDTH-1:0] sum_next;

    // Slice bits of the partial sum are still zero upstream, so OR-ing the
    // new slice in places it without disturbing the lower, finished slices.
    always_comb begin
        slice_sum = {1'b0, up_a[LO +: S]} + {1'b0, up_b[LO +: S]} + {{S{1'b0}}, up_carry};
        sum_next  = up_sum | (WIDTH'(slice_sum[S-1:0]) << LO);
    end

    // An empty stage or one whose contents leave this cycle can take a beat.
    assign up_ready = !valid_reg || dn_ready;

    // Stage register: load on transfer, hold while stalled, drop on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            op_reg    <= OP_ADD;
        end else if (up_ready) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                a_reg     <= up_a;
                b_reg     <= up_b;
                sum_reg   <= sum_next;
                carry_reg <= slice_sum[S];
                op_reg    <= up_op;
            end
        end
    end

    assign dn_valid = valid_reg;
    assign dn_a     = a_reg;
    assign dn_b     = b_reg;
    assign dn_sum   = sum_reg;
    assign dn_carry = carry_reg;
    assign dn_op    = op_reg;
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with optional signed saturation. The carry
// chain is split across STAGES registered slices; latency equals STAGES and a
// new beat can be accepted every cycle.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    pipelined_adder_if.slave    bus
);
    if (STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0 || WIDTH > MAX_W) begin : g_bad_params
        $error("pipelined_adder: WIDTH must divide by STAGES and STAGES must be 1..4");
    end

    // Index 0 is the conditioned input; index k+1 is the output of stage k.
    logic             stg_valid [0:STAGES];
    logic             stg_ready [0:STAGES];
    logic [WIDTH-1:0] stg_a     [0:STAGES];
    logic [WIDTH-1:0] stg_b     [0:STAGES];
    logic [WIDTH-1:0] stg_sum   [0:STAGES];
    logic             stg_carry [0:STAGES];
    op_e              stg_op    [0:STAGES];

    // Subtraction is a + ~b + 1, so conditioning happens before stage 0.
    always_comb begin
        stg_valid[0] = bus.in_valid;
        stg_a[0]     = bus.in_a;
        stg_b[0]     = is_sub(bus.in_op) ? ~bus.in_b : bus.in_b;
        stg_sum[0]   = '0;
        stg_carry[0] = is_sub(bus.in_op);
        stg_op[0]    = bus.in_op;
    end

    assign bus.in_ready      = stg_ready[0];
    assign stg_ready[STAGES] = bus.out_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        adder_slice #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (gi)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (stg_valid[gi]),
            .up_ready (stg_ready[gi]),
            .up_a     (stg_a[gi]),
            .up_b     (stg_b[gi]),
            .up_sum   (stg_sum[gi]),
            .up_carry (stg_carry[gi]),
            .up_op    (stg_op[gi]),
            .dn_valid (stg_valid[gi+1]),
            .dn_ready (stg_ready[gi+1]),
            .dn_a     (stg_a[gi+1]),
            .dn_b     (stg_b[gi+1]),
            .dn_sum   (stg_sum[gi+1]),
            .dn_carry (stg_carry[gi+1]),
            .dn_op    (stg_op[gi+1])
        );
    end

    logic             a_msb;
    logic             b_msb;
    logic             raw_msb;
    logic             ovf;
    logic [WIDTH-1:0] sat_y;

    // Flags and saturation from the fully summed last-stage register. The
    // overflow direction follows operand A's sign, since both effective
    // operands share that sign whenever overflow occurs.
    always_comb begin
        a_msb   = stg_a[STAGES][WIDTH-1];
        b_msb   = stg_b[STAGES][WIDTH-1];
        raw_msb = stg_sum[STAGES][WIDTH-1];
        ovf     = (a_msb == b_msb) && (raw_msb != a_msb);
        sat_y   = {a_msb, {(WIDTH-1){~a_msb}}};
    end

    assign bus.out_valid = stg_valid[STAGES];
    assign bus.out_y     = (is_sat(stg_op[STAGES]) && ovf) ? sat_y : stg_sum[STAGES];
    assign bus.out_carry = is_sub(stg_op[STAGES]) ? ~stg_carry[STAGES] : stg_carry[STAGES];
    assign bus.out_ovf   = ovf;

    logic [WIDTH-1:0] orig_b;
    result_t          model_res;

    // Undo the conditioning to recover the caller's operand B, then run the
    // unpipelined reference on the beat currently presented at the output.
    always_comb begin
        orig_b    = is_sub(stg_op[STAGES]) ? ~stg_b[STAGES] : stg_b[STAGES];
        model_res = ref_add(wide_t'(stg_a[STAGES]), wide_t'(orig_b), stg_op[STAGES], WIDTH);
    end

    a_result_matches_model: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid |-> (model_res == {wide_t'(bus.out_y), bus.out_carry, bus.out_ovf}));
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=2): directed
// corner cases with literal expectations, backpressure, mid-flight reset and
// a randomized run scored against an arithmetic model of the adder.
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total   = 0;
    int   bad     = 0;
    int   pushed  = 0;
    int   popped  = 0;
    int   flushed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Signed/unsigned arithmetic on 64-bit integers decides every output.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input op_e op);
        exp_t            e;
        longint          sa;
        longint          sb;
        longint          t;
        longint unsigned ua;
        longint unsigned ub;
        logic            sub;
        logic            sat;
        sub   = (op == OP_SUB) || (op == OP_SSUB);
        sat   = (op == OP_SADD) || (op == OP_SSUB);
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        t     = sub ? (sa - sb) : (sa + sb);
        ua    = {32'd0, a};
        ub    = {32'd0, b};
        e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        e.c   = sub ? (ua < ub) : ((ua + ub) > 64'hFFFF_FFFF);
        if (sat && e.ovf) e.y = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else              e.y = t[31:0];
        return e;
    endfunction

    // Scoreboard: sample mid-cycle; outputs checked on every valid cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            flushed += exp_q.size();
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q[0];
                    check("scoreboard", {30'd0, bus.out_y, bus.out_carry, bus.out_ovf},
                          {30'd0, mon_e.y, mon_e.c, mon_e.ovf});
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
                pushed++;
            end
        end
    end

    // Single beat into an empty pipe; expects literal results after 2 cycles.
    task automatic send_one(input string name, input logic [31:0] a, input logic [31:0] b,
                            input op_e op, input logic [31:0] y, input logic c, input logic v);
        exp_t    m;
        result_t r;
        m = model(a, b, op);
        r = ref_add(wide_t'(a), wide_t'(b), op, WIDTH);
        check({name, "_model"}, {30'd0, m.y, m.c, m.ovf}, {30'd0, y, c, v});
        check({name, "_pkgref"}, {30'd0, r.y[31:0], r.carry, r.ovf}, {30'd0, y, c, v});
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({name, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check({name, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_y"}, 64'(bus.out_y), 64'(y));
        check({name, "_carry"}, 64'(bus.out_carry), 64'(c));
        check({name, "_ovf"}, 64'(bus.out_ovf), 64'(v));
        @(posedge clk); #1;
    endtask

    initial begin
        int          idx;
        int          stall;
        bit          seen;
        bit          saw_block;
        bit          took;
        int          sent;
        int          cyc;
        logic [31:0] held_y;
        logic [31:0] got[$];

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_ADD;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_y", 64'(bus.out_y), 64'd0);
        check("rst_out_carry", 64'(bus.out_carry), 64'd0);
        check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed corner cases
        send_one("carry_out",  32'h0000_0001, 32'hFFFF_FFFF, OP_ADD,  32'h0000_0000, 1'b1, 1'b0);
        send_one("slice_carry", 32'h0000_FFFF, 32'h0000_0001, OP_ADD,  32'h0001_0000, 1'b0, 1'b0);
        send_one("add_wrap",   32'h7FFF_FFFF, 32'h0000_0001, OP_ADD,  32'h8000_0000, 1'b0, 1'b1);
        send_one("sadd_sat",   32'h7FFF_FFFF, 32'h0000_0001, OP_SADD, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send_one("ssub_sat",   32'h8000_0000, 32'h0000_0001, OP_SSUB, 32'h8000_0000, 1'b0, 1'b1);
        send_one("sub_borrow", 32'h0000_0000, 32'h0000_0001, OP_SUB,  32'hFFFF_FFFF, 1'b1, 1'b0);

        // Backpressure: five back-to-back beats, 3-cycle stall at first output
        idx       = 0;
        stall     = 0;
        seen      = 1'b0;
        saw_block = 1'b0;
        held_y    = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            bus.in_valid = (idx < 5);
            bus.in_a     = 32'(idx);
            bus.in_b     = 32'(idx);
            bus.in_op    = OP_ADD;
            if (bus.out_valid && !seen) begin
                seen   = 1'b1;
                stall  = 3;
                held_y = bus.out_y;
            end
            if (stall > 0) begin
                if (stall < 3) check("bp_stall_hold", 64'(bus.out_y), 64'(held_y));
                bus.out_ready = 1'b0;
                stall--;
            end else begin
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            if (!bus.in_ready) saw_block = 1'b1;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_y);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < got.size(); i++) check("bp_order", 64'(got[i]), 64'(2 * i));
        check("bp_in_ready_dropped", 64'(saw_block), 64'd1);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h0000_0010;
        bus.in_b      = 32'h0000_0020;
        bus.in_op     = OP_ADD;
        @(posedge clk); #1;
        bus.in_a      = 32'h0000_0030;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        check("mr_inflight", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mr_valid_cleared", 64'(bus.out_valid), 64'd0);
        check("mr_y_cleared", 64'(bus.out_y), 64'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("mr_valid_stays_clear", 64'(bus.out_valid), 64'd0);
        send_one("mr_after", 32'h1234_5678, 32'h1111_1111, OP_ADD, 32'h2345_6789, 1'b0, 1'b0);

        // Randomized regression
        sent = 0;
        took = 1'b0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (!bus.in_valid || took) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    case ($urandom_range(0, 5))
                        0:       bus.in_a = 32'h7FFF_FFFF;
                        1:       bus.in_a = 32'h8000_0000;
                        default: bus.in_a = $urandom;
                    endcase
                    case ($urandom_range(0, 5))
                        0:       bus.in_b = 32'h0000_0001;
                        1:       bus.in_b = 32'hFFFF_FFFF;
                        default: bus.in_b = $urandom;
                    endcase
                    bus.in_op = op_e'($urandom_range(0, 3));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (took) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_sent", 64'(sent), 64'd1000);

        // Drain and account for every beat
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk); #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_idle", 64'(bus.out_valid), 64'd0);
        check("beat_accounting", 64'(popped + flushed), 64'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
